// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage Y86-64 core: hazard stall/bubble generation,
// IDLE/RUN/HALTED sequencing and saturating performance counters.
`timescale 1ns/1ps

module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clr_cnt,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_cnd,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             W_bubble,
    output logic             set_cc,
    output logic             halted,
    output logic [1:0]       cpu_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [1:0] S_AOK    = 2'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } runState_t;

    runState_t state;
    runState_t stateNext;

    logic loadUse;
    logic retHazard;
    logic misPred;
    logic mExc;
    logic wExc;
    logic retireNow;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value,
                                                input logic             en);
        logic [CNT_W-1:0] result;
        result = value;
        if (en && (value != {CNT_W{1'b1}}))
            result = value + 1'b1;
        return result;
    endfunction

    // Hazard detection; a load whose destination is RNONE never creates a dependency.
    always_comb begin
        loadUse   = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                    (E_dstM != R_NONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        retHazard = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        misPred   = (E_icode == I_JXX) && !e_cnd;
        mExc      = (m_stat != S_AOK);
        wExc      = (W_stat != S_AOK);
        retireNow = (W_stat == S_AOK) && (W_icode != I_NOP);
    end

    always_comb begin
        stateNext = state;
        F_stall   = 1'b0;
        D_stall   = 1'b0;
        D_bubble  = 1'b0;
        E_bubble  = 1'b0;
        M_bubble  = 1'b0;
        W_stall   = 1'b0;
        W_bubble  = 1'b0;
        set_cc    = 1'b0;
        case (state)
            IDLE: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_bubble = 1'b1;
                if (start)
                    stateNext = RUN;
            end
            RUN: begin
                // A load/use stall on D takes precedence over the ret bubble.
                F_stall  = loadUse | retHazard;
                D_stall  = loadUse;
                D_bubble = misPred | (retHazard & !loadUse);
                E_bubble = misPred | loadUse;
                M_bubble = mExc | wExc;
                W_stall  = wExc;
                set_cc   = (E_icode == I_OPQ) & !mExc & !wExc;
                if (wExc)
                    stateNext = HALTED;
            end
            HALTED: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                W_stall  = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            halted   <= 1'b0;
            cpu_stat <= S_AOK;
        end else begin
            state  <= stateNext;
            halted <= (stateNext == HALTED);
            if ((state == RUN) && wExc)
                cpu_stat <= W_stat;
        end
    end

    // Counters only advance during RUN; a clear beats any same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            retire_cnt <= '0;
        end else if (state == RUN) begin
            cycle_cnt  <= satInc(cycle_cnt, 1'b1);
            stall_cnt  <= satInc(stall_cnt, F_stall);
            bubble_cnt <= satInc(bubble_cnt, D_bubble | E_bubble);
            retire_cnt <= satInc(retire_cnt, retireNow);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: table of RUN-state hazard vectors plus hand-written
// sequences for start, halt, reset and counter saturation/clear.
`timescale 1ns/1ps

module tb_pipe_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          clr_cnt;
    logic [3:0]    D_icode, E_icode, M_icode, W_icode;
    logic [3:0]    E_dstM, d_srcA, d_srcB;
    logic          e_cnd;
    logic [1:0]    m_stat, W_stat;
    logic          F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble, set_cc;
    logic          halted;
    logic [1:0]    cpu_stat;
    logic [CW-1:0] cycle_cnt, stall_cnt, bubble_cnt, retire_cnt;
    logic [7:0]    ctl;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] dIc;
        logic [3:0] eIc;
        logic [3:0] mIc;
        logic [3:0] eDst;
        logic [3:0] srcA;
        logic [3:0] srcB;
        logic       cnd;
        logic [1:0] mSt;
        logic [1:0] wSt;
        logic [7:0] expCtl;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    // Control bits packed {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,W_bubble,set_cc}
    localparam logic [7:0] CTL_IDLE   = 8'hBA;
    localparam logic [7:0] CTL_HALTED = 8'hDC;

    assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble, set_cc};

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .clr_cnt(clr_cnt),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_cnd(e_cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .W_bubble(W_bubble), .set_cc(set_cc),
        .halted(halted), .cpu_stat(cpu_stat),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
        .retire_cnt(retire_cnt)
    );

    function automatic vec_t mkVec(input logic [3:0] d, input logic [3:0] e, input logic [3:0] m,
                                   input logic [3:0] dst, input logic [3:0] a, input logic [3:0] b,
                                   input logic c, input logic [1:0] ms, input logic [1:0] ws,
                                   input logic [7:0] ex);
        vec_t v;
        v.dIc = d; v.eIc = e; v.mIc = m; v.eDst = dst; v.srcA = a; v.srcB = b;
        v.cnd = c; v.mSt = ms; v.wSt = ws; v.expCtl = ex;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic setNeutral();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
        E_dstM  = 4'hF; d_srcA  = 4'hF; d_srcB  = 4'hF;
        e_cnd   = 1'b1; m_stat  = 2'd0; W_stat  = 2'd0;
    endtask

    task automatic applyStimulus(input vec_t v);
        D_icode = v.dIc; E_icode = v.eIc; M_icode = v.mIc;
        E_dstM  = v.eDst; d_srcA = v.srcA; d_srcB = v.srcB;
        e_cnd   = v.cnd;  m_stat = v.mSt;  W_stat = v.wSt;
        W_icode = 4'h1;
    endtask

    task automatic checkCounters(input string tag, input int cyc, input int stl,
                                 input int bub, input int ret);
        checkOutput({tag, ".cycle"},  32'(cycle_cnt),  32'(cyc));
        checkOutput({tag, ".stall"},  32'(stall_cnt),  32'(stl));
        checkOutput({tag, ".bubble"}, 32'(bubble_cnt), 32'(bub));
        checkOutput({tag, ".retire"}, 32'(retire_cnt), 32'(ret));
    endtask

    function automatic int sat(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    initial begin
        int expCyc, expStl, expBub;

        vecs[0]  = mkVec(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0, 8'h00);
        vecs[1]  = mkVec(4'h1, 4'h5, 4'h1, 4'h3, 4'h3, 4'hF, 1'b1, 2'd0, 2'd0, 8'hD0);
        vecs[2]  = mkVec(4'h1, 4'hB, 4'h1, 4'h4, 4'hF, 4'h4, 1'b1, 2'd0, 2'd0, 8'hD0);
        vecs[3]  = mkVec(4'h1, 4'h5, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0, 8'h00);
        vecs[4]  = mkVec(4'h1, 4'h5, 4'h1, 4'h3, 4'h2, 4'h4, 1'b1, 2'd0, 2'd0, 8'h00);
        vecs[5]  = mkVec(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 2'd0, 2'd0, 8'h30);
        vecs[6]  = mkVec(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0, 8'h00);
        vecs[7]  = mkVec(4'h9, 4'h5, 4'h1, 4'h3, 4'h3, 4'hF, 1'b1, 2'd0, 2'd0, 8'hD0);
        vecs[8]  = mkVec(4'h9, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0, 8'hA0);
        vecs[9]  = mkVec(4'h1, 4'h1, 4'h9, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0, 8'hA0);
        vecs[10] = mkVec(4'h1, 4'h9, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0, 8'hA0);
        vecs[11] = mkVec(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0, 8'h01);
        vecs[12] = mkVec(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd2, 2'd0, 8'h08);
        vecs[13] = mkVec(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd3, 2'd0, 8'h08);
        vecs[14] = mkVec(4'h9, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 2'd0, 2'd0, 8'hB0);

        reset = 1'b1; start = 1'b0; clr_cnt = 1'b0;
        setNeutral();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset.ctl", 32'(ctl), 32'(CTL_IDLE));
        checkOutput("reset.halted", 32'(halted), 0);
        checkOutput("reset.cpuStat", 32'(cpu_stat), 0);
        checkCounters("reset", 0, 0, 0, 0);

        // IDLE must mask set_cc and must not count retirements
        E_icode = 4'h6; W_icode = 4'h6;
        #1;
        checkOutput("idle.ctl", 32'(ctl), 32'(CTL_IDLE));
        @(negedge clk);
        checkCounters("idle", 0, 0, 0, 0);

        setNeutral();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checkOutput("run.ctl", 32'(ctl), 0);
        checkOutput("run.cycle0", 32'(cycle_cnt), 0);
        repeat (3) @(negedge clk);
        checkOutput("run.cycle3", 32'(cycle_cnt), 3);

        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #1;
        checkOutput("clr.cycle", 32'(cycle_cnt), 0);

        expCyc = 0; expStl = 0; expBub = 0;
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d.ctl", i), 32'(ctl), 32'(vecs[i].expCtl));
            @(negedge clk);
            expCyc++;
            if (vecs[i].expCtl[7]) expStl++;
            if (vecs[i].expCtl[5] || vecs[i].expCtl[4]) expBub++;
        end
        setNeutral();
        checkCounters("table", sat(expCyc), sat(expStl), sat(expBub), 0);

        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        W_icode = 4'h6;
        @(negedge clk);
        W_icode = 4'h0;
        @(negedge clk);
        W_icode = 4'h1;
        @(negedge clk);
        checkCounters("retire", 3, 0, 0, 2);

        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        W_stat  = 2'd2;
        E_icode = 4'h6;
        #1;
        checkOutput("wexc.ctl", 32'(ctl), 32'h0C);
        checkOutput("wexc.halted", 32'(halted), 0);
        @(negedge clk);
        checkOutput("halt.halted", 32'(halted), 1);
        checkOutput("halt.cpuStat", 32'(cpu_stat), 2);
        checkOutput("halt.ctl", 32'(ctl), 32'(CTL_HALTED));
        checkCounters("halt", 1, 0, 0, 0);

        W_stat = 2'd0; W_icode = 4'h6; D_icode = 4'h9; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        checkOutput("sticky.halted", 32'(halted), 1);
        checkOutput("sticky.cpuStat", 32'(cpu_stat), 2);
        checkOutput("sticky.ctl", 32'(ctl), 32'(CTL_HALTED));
        checkCounters("sticky", 1, 0, 0, 0);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        setNeutral();
        #1;
        checkOutput("haltReset.halted", 32'(halted), 0);
        checkOutput("haltReset.cpuStat", 32'(cpu_stat), 0);
        checkOutput("haltReset.ctl", 32'(ctl), 32'(CTL_IDLE));
        checkOutput("haltReset.cycle", 32'(cycle_cnt), 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midRun.cycle", 32'(cycle_cnt), 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midRun.ctl", 32'(ctl), 32'(CTL_IDLE));
        checkOutput("midRun.cycleReset", 32'(cycle_cnt), 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        D_icode = 4'h9;
        repeat (20) @(negedge clk);
        checkCounters("sat", 15, 15, 15, 0);

        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #1;
        checkOutput("satClr.cycle", 32'(cycle_cnt), 0);
        checkOutput("satClr.stall", 32'(stall_cnt), 0);
        @(negedge clk);
        checkOutput("afterClr.cycle", 32'(cycle_cnt), 1);
        checkOutput("afterClr.stall", 32'(stall_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the five-stage Y86-64 pipelined processor. It watches stage icodes, register IDs, the branch condition and status codes. It drives the stall and bubble inputs of the F, D, E, M and W pipeline registers, plus the condition-code write enable. A run-state FSM (IDLE/RUN/HALTED) and saturating performance counters make it the sequencing point for the whole datapath.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high; FSM to IDLE, counters and cpu_stat to 0
start  in  1  one-cycle pulse; IDLE->RUN
clr_cnt  in  1  synchronous clear of all perf counters
D_icode  in  4  icode in D register
E_icode  in  4  icode in E register
M_icode  in  4  icode in M register
W_icode  in  4  icode in W register
E_dstM  in  4  dstM in E register
d_srcA  in  4  srcA decoded in D stage
d_srcB  in  4  srcB decoded in D stage
e_cnd  in  1  branch condition computed in E stage
m_stat  in  2  status out of M stage
W_stat  in  2  status in W register
F_stall  out  1  hold F register
D_stall  out  1  hold D register
D_bubble  out  1  load NOP into D
E_bubble  out  1  load NOP into E
M_bubble  out  1  load NOP into M
W_stall  out  1  hold W register
W_bubble  out  1  load NOP into W
set_cc  out  1  condition-code write enable
halted  out  1  FSM in HALTED
cpu_stat  out  2  registered final status
cycle_cnt  out  CNT_W  cycles spent in RUN
stall_cnt  out  CNT_W  RUN cycles with F_stall=1
bubble_cnt  out  CNT_W  RUN cycles with D_bubble or E_bubble=1
retire_cnt  out  CNT_W  retired instructions

Behaviour:
- Encodings. icode: HALT=0, NOP=1, MRMOVQ=5, OPQ=6, JXX=7, RET=9, POPQ=B. RNONE=F. stat: AOK=0, HLT=1, ADR=2, INS=3. A status is "exc" when it is not AOK.
- Hazard terms, all combinational:
  - loaduse = E_icode in {5,B} and E_dstM!=F and E_dstM in {d_srcA, d_srcB}.
  - ret = 9 in {D_icode, E_icode, M_icode}.
  - mispred = E_icode==7 and !e_cnd.
- RUN outputs, all combinational (same-cycle, consumed at next edge):
  - F_stall = loaduse|ret
  - D_stall = loaduse
  - D_bubble = mispred | (ret & !loaduse)
  - E_bubble = mispred | loaduse
  - M_bubble = exc(m_stat) | exc(W_stat)
  - W_stall = exc(W_stat)
  - W_bubble = 0
  - set_cc = E_icode==6 & !exc(m_stat) & !exc(W_stat)
- Invariant: no stage ever sees stall and bubble together.
- IDLE outputs: F_stall=1, D_bubble=E_bubble=M_bubble=W_bubble=1, all else 0. This flushes the pipe to NOPs.
- HALTED outputs: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, all else 0. This freezes the pipe.
- FSM:
  - Reset state is IDLE.
  - IDLE->RUN on start.
  - RUN->HALTED when exc(W_stat) is sampled at an edge. On that edge cpu_stat<=W_stat.
  - HALTED is sticky; only reset leaves it.
  - start is ignored outside IDLE.
  - halted = (state==HALTED), registered.
- Reset values: halted=0, cpu_stat=0, all counters=0. Reset mid-RUN or in HALTED returns to IDLE on the next edge.
- Counters: update only in RUN.
  - cycle_cnt: +1 every RUN cycle.
  - stall_cnt: +1 when F_stall=1.
  - bubble_cnt: +1 when D_bubble|E_bubble=1.
  - retire_cnt: +1 when W_stat==AOK and W_icode!=NOP.
  - All saturate at 2^CNT_W-1.
  - clr_cnt wins over a same-cycle increment.
  - Counters hold their values in IDLE and HALTED.

Test Plan:
- Reset, start held 0 → IDLE flush outputs, counters 0, cpu_stat=0. Pulse start → RUN from next edge; cycle_cnt increments each cycle.
- RUN, E_icode=5, E_dstM=3, d_srcA=3 → F_stall=D_stall=E_bubble=1, D_bubble=0, stall_cnt+1. Repeat with E_dstM=F, d_srcA=F → all stalls and bubbles 0.
- RUN, E_icode=7, e_cnd=0 → D_bubble=E_bubble=1, F_stall=0. Same with e_cnd=1 → all 0.
- RUN, D_icode=9 plus the load/use case → F_stall=1, D_stall=1, D_bubble=0, E_bubble=1. Then D_icode=9 alone → F_stall=1, D_bubble=1.
- RUN, E_icode=6, m_stat=2 → M_bubble=1, set_cc=0. Then W_stat=2 → W_stall=1. Next edge: halted=1, cpu_stat=2, counters frozen, start ignored. Reset → IDLE with cpu_stat=0.
- CNT_W=4, 20 RUN cycles → cycle_cnt=15 (saturated). Assert clr_cnt while incrementing → next value 0.
